// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Timing scheduler in front of the traffic-light FSM. It decides when the
// active direction's green ends (min green, gap-out, max-out), times the
// yellow interval and pulses o_newState to flip right-of-way.
// All timing runs in prescaled ticks of TICK_DIV clocks and only advances
// while i_countEnable is high.
// Optional feature: define PED_REQ_EN to add the i_pedReq input and drive
// o_pedWalk; without it the port is absent and o_pedWalk is tied low.
// o_phase is the FSM state register itself (00 START, 01 GREEN,
// 10 YELLOW, 11 CHANGE).
module traffic_phase_scheduler #(
  parameter int TICK_DIV    = 1000,
  parameter int GREEN_MIN   = 10,
  parameter int GREEN_MAX   = 30,
  parameter int YELLOW_TIME = 4,
  parameter int EXTEND      = 3,
  parameter int CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_nreset,
  input  logic       i_countEnable,
  input  logic       i_NSdemand,
  input  logic       i_EWdemand,
`ifdef PED_REQ_EN
  input  logic       i_pedReq,
`endif
  output logic       o_newState,
  output logic       o_nextLight,
  output logic       o_dirEW,
  output logic [1:0] o_phase,
  output logic       o_pedWalk
);

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10,
    ST_CHANGE = 2'b11
  } phase_t;

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] G_MIN   = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX   = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] X_EXT   = CNT_W'(EXTEND);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_TIME - 1);

  phase_t            state;
  logic [PS_W-1:0]   ps_cnt;
  logic [CNT_W-1:0]  pc;      // green ticks in GREEN, yellow ticks in YELLOW
  logic [CNT_W-1:0]  gc;      // ticks since own-direction demand was last seen
  logic              tick;
  logic              own_demand;
  logic              cross_demand;
  logic              ped_go;
  logic              green_exit;

  assign o_phase      = state;
  assign tick         = i_countEnable && (ps_cnt == PS_LAST);
  assign own_demand   = o_dirEW ? i_EWdemand : i_NSdemand;
  assign cross_demand = o_dirEW ? i_NSdemand : i_EWdemand;

  // Exit uses the registered counters; the move to YELLOW lands next cycle.
  // Gated on i_countEnable so a stalled scheduler never changes phase.
  assign green_exit = i_countEnable && (pc >= G_MIN) &&
                      (ped_go || (cross_demand && ((gc >= X_EXT) || (pc >= G_MAX))));

  // Phase FSM with prescaler and counters; counters clear on every phase entry.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state       <= ST_START;
      ps_cnt      <= '0;
      pc          <= '0;
      gc          <= '0;
      o_newState  <= 1'b0;
      o_nextLight <= 1'b0;
      o_dirEW     <= 1'b0;
    end else begin
      if (i_countEnable) ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      o_newState <= 1'b0;
      case (state)
        ST_START: begin
          if (i_countEnable) begin
            state  <= ST_GREEN;
            ps_cnt <= '0;
            pc     <= '0;
            gc     <= '0;
          end
        end
        ST_GREEN: begin
          if (own_demand)             gc <= '0;
          else if (tick && gc < X_EXT) gc <= gc + 1'b1;
          if (tick && pc < G_MAX)     pc <= pc + 1'b1;
          if (green_exit) begin
            state       <= ST_YELLOW;
            o_nextLight <= 1'b1;
            ps_cnt      <= '0;
            pc          <= '0;
            gc          <= '0;
          end
        end
        ST_YELLOW: begin
          if (tick) begin
            if (pc == Y_LAST) begin
              state       <= ST_CHANGE;
              o_nextLight <= 1'b0;
              o_newState  <= 1'b1;
              ps_cnt      <= '0;
              pc          <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: begin  // ST_CHANGE: single cycle, flip right-of-way
          state   <= ST_GREEN;
          o_dirEW <= ~o_dirEW;
          ps_cnt  <= '0;
          pc      <= '0;
          gc      <= '0;
        end
      endcase
    end
  end

`ifdef PED_REQ_EN
  localparam logic WALK_ON = (GREEN_MIN > 0);
  logic ped_pending;

  assign ped_go = ped_pending;

  // Latch pedestrian requests; the request served in CHANGE becomes the walk
  // signal of the next green, while a request seen during CHANGE is kept.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      ped_pending <= 1'b0;
      o_pedWalk   <= 1'b0;
    end else begin
      if (state == ST_CHANGE) ped_pending <= i_pedReq;
      else if (i_pedReq)      ped_pending <= 1'b1;
      if (state == ST_CHANGE)
        o_pedWalk <= ped_pending && WALK_ON;
      else if (state == ST_GREEN && tick && pc == G_MIN - 1'b1)
        o_pedWalk <= 1'b0;
    end
  end
`else
  assign ped_go    = 1'b0;
  assign o_pedWalk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with small timing parameters
// (TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_TIME=2, EXTEND=2).
// Stimulus and sampling happen 1 time unit after the rising edge.
module tb_traffic_phase_scheduler;

  logic       clk;
  logic       nreset;
  logic       count_en;
  logic       ns_demand;
  logic       ew_demand;
  logic       ped_req;
  logic       new_state;
  logic       next_light;
  logic       dir_ew;
  logic [1:0] phase;
  logic       ped_walk;

  int total = 0;
  int bad   = 0;

  traffic_phase_scheduler #(
    .TICK_DIV(4), .GREEN_MIN(3), .GREEN_MAX(6), .YELLOW_TIME(2), .EXTEND(2), .CNT_W(8)
  ) dut (
    .i_clk        (clk),
    .i_nreset     (nreset),
    .i_countEnable(count_en),
    .i_NSdemand   (ns_demand),
    .i_EWdemand   (ew_demand),
`ifdef PED_REQ_EN
    .i_pedReq     (ped_req),
`endif
    .o_newState   (new_state),
    .o_nextLight  (next_light),
    .o_dirEW      (dir_ew),
    .o_phase      (phase),
    .o_pedWalk    (ped_walk)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for a phase; an expired budget counts as a failure.
  task automatic wait_phase(input logic [1:0] ph, input int budget);
    int n = 0;
    while (phase !== ph && n < budget) begin
      step();
      n++;
    end
    total++;
    if (phase !== ph) begin
      bad++;
      $display("FAIL wait_phase: got %b want %b after %0d cycles", phase, ph, n);
    end
  endtask

  // Reset, then release with count enable high; leaves us in the first
  // cycle of GREEN NS (entry cycle).
  task automatic reset_to_green();
    nreset = 1'b0; count_en = 1'b0; ns_demand = 1'b0; ew_demand = 1'b0; ped_req = 1'b0;
    step(); step();
    nreset = 1'b1; count_en = 1'b1;
    step();
    total++;
    if (phase !== 2'b01 || dir_ew !== 1'b0) begin
      bad++;
      $display("FAIL reset_to_green: phase=%b dir=%b want 01/0", phase, dir_ew);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; count_en = 1'b0; ns_demand = 1'b0; ew_demand = 1'b0; ped_req = 1'b0;
    #2;
    total++;
    if ({phase, new_state, next_light, dir_ew, ped_walk} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: phase=%b ns=%b nl=%b dir=%b walk=%b want all 0",
               phase, new_state, next_light, dir_ew, ped_walk);
    end
    step();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (phase !== 2'b00) begin
        bad++;
        $display("FAIL start_hold: cycle %0d phase=%b want 00", i, phase);
      end
    end
    count_en = 1'b1;
    step();
    total++;
    if (phase !== 2'b01 || dir_ew !== 1'b0) begin
      bad++;
      $display("FAIL start_to_green: phase=%b dir=%b want 01/0", phase, dir_ew);
    end
  endtask

  task automatic test_no_demand();
    reset_to_green();
    for (int k = 1; k <= 200; k++) begin
      step();
      total++;
      if (phase !== 2'b01 || new_state !== 1'b0) begin
        bad++;
        $display("FAIL no_demand: k=%0d phase=%b newState=%b want 01/0", k, phase, new_state);
      end
    end
  endtask

  task automatic test_gap_out();
    logic [1:0] exp_ph;
    reset_to_green();
    ew_demand = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      exp_ph = (k <= 12) ? 2'b01 : (k <= 20) ? 2'b10 : (k == 21) ? 2'b11 : 2'b01;
      total++;
      if (phase !== exp_ph || next_light !== (k >= 13 && k <= 20) ||
          new_state !== (k == 21) || dir_ew !== (k >= 22)) begin
        bad++;
        $display("FAIL gap_out: k=%0d phase=%b nl=%b ns=%b dir=%b want %b/%b/%b/%b", k,
                 phase, next_light, new_state, dir_ew, exp_ph,
                 (k >= 13 && k <= 20), (k == 21), (k >= 22));
      end
    end
  endtask

  task automatic test_both_demand();
    int len;
    reset_to_green();
    ns_demand = 1'b1; ew_demand = 1'b1;
    for (int g = 0; g < 3; g++) begin
      total++;
      if (dir_ew !== g[0]) begin
        bad++;
        $display("FAIL both_dir: green %0d dir=%b want %b", g, dir_ew, g[0]);
      end
      len = 0;
      while (phase === 2'b01 && len < 100) begin
        len++;
        step();
      end
      total++;
      if (len != 25) begin
        bad++;
        $display("FAIL both_len: green %0d length=%0d want 25", g, len);
      end
      wait_phase(2'b01, 40);
    end
  endtask

  task automatic test_yellow_stall();
    int cnt = 0;
    reset_to_green();
    ew_demand = 1'b1;
    wait_phase(2'b10, 40);
    while (next_light === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 3)  count_en = 1'b0;
      if (cnt == 13) count_en = 1'b1;
      step();
    end
    total++;
    if (cnt != 18) begin
      bad++;
      $display("FAIL yellow_stall_len: yellow=%0d want 18", cnt);
    end
    total++;
    if (phase !== 2'b11 || new_state !== 1'b1 || next_light !== 1'b0) begin
      bad++;
      $display("FAIL yellow_stall_change: phase=%b ns=%b nl=%b want 11/1/0",
               phase, new_state, next_light);
    end
  endtask

  // Continues from the CHANGE left by test_yellow_stall into GREEN EW.
  task automatic test_reset_mid_yellow();
    ew_demand = 1'b0; ns_demand = 1'b1;
    step();
    wait_phase(2'b10, 60);
    step(); step();
    total++;
    if (dir_ew !== 1'b1 || next_light !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_yellow: dir=%b nl=%b want 1/1", dir_ew, next_light);
    end
    nreset = 1'b0;
    #1;
    total++;
    if (phase !== 2'b00 || next_light !== 1'b0 || dir_ew !== 1'b0 || new_state !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: phase=%b nl=%b dir=%b ns=%b want 00/0/0/0",
               phase, next_light, dir_ew, new_state);
    end
    step();
    nreset = 1'b1; count_en = 1'b1;
    step();
    total++;
    if (phase !== 2'b01 || dir_ew !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: phase=%b dir=%b want 01/0", phase, dir_ew);
    end
  endtask

`ifdef PED_REQ_EN
  task automatic test_ped();
    logic [1:0] exp_ph;
    reset_to_green();
    for (int k = 1; k <= 40; k++) begin
      step();
      ped_req = (k == 5);
      exp_ph = (k <= 12) ? 2'b01 : (k <= 20) ? 2'b10 : (k == 21) ? 2'b11 : 2'b01;
      total++;
      if (phase !== exp_ph || ped_walk !== (k >= 22 && k <= 33) || dir_ew !== (k >= 22)) begin
        bad++;
        $display("FAIL ped: k=%0d phase=%b walk=%b dir=%b want %b/%b/%b", k, phase,
                 ped_walk, dir_ew, exp_ph, (k >= 22 && k <= 33), (k >= 22));
      end
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_no_demand();
    test_gap_out();
    test_both_demand();
    test_yellow_stall();
    test_reset_mid_yellow();
`ifdef PED_REQ_EN
    test_ped();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
